// File: rtl/comb01_pkg.sv
// Shared definitions for the comb01 BIST controller.
// State encoding, stimulus table and golden truth table.
package comb01_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Packed so that entry i sits at TST_VEC[i]; default vector i = i.
    localparam logic [7:0][2:0] TST_VEC = {
        3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0
    };

    // Bit k is the expected F for X = k.
    localparam logic [7:0] EXP_F = 8'b1001_0110;

    localparam logic [3:0] ERR_MAX = 4'd8;

    function automatic logic [2:0] tst_vec(input logic [2:0] i);
        return TST_VEC[i];
    endfunction

    function automatic logic exp_f(input logic [2:0] x);
        return EXP_F[x];
    endfunction

endpackage

// File: rtl/comb01_bist_ctrl_if.sv
// Bus between a comb01 BIST controller and its harness.
// master: drives start/abort/F; slave: the controller.
interface comb01_bist_ctrl_if;

    logic       start;
    logic       abort;
    logic       F;
    logic [2:0] X;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_map;

    modport master (
        output start, abort, F,
        input  X, busy, done, pass, err_count, fail_map
    );

    modport slave (
        input  start, abort, F,
        output X, busy, done, pass, err_count, fail_map
    );

endinterface

// File: rtl/comb01.sv
// comb01 combinational block under test.
// x_i: 3-bit input; f_o: odd parity of x_i.
module comb01 (
    input  logic [2:0] x_i,
    output logic       f_o
);

    assign f_o = ^x_i;

endmodule

// File: rtl/comb01_bist_top.sv
// Wrapper joining the BIST controller to a comb01 instance.
// start_i/abort_i in; x_o, busy_o, done_o, pass_o, counts out.
module comb01_bist_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic [2:0] x_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] err_count_o,
    output logic [7:0] fail_map_o
);

    comb01_bist_ctrl_if bus ();

    assign bus.start = start_i;
    assign bus.abort = abort_i;

    comb01 u_comb01 (
        .x_i (bus.X),
        .f_o (bus.F)
    );

    comb01_bist_ctrl u_ctrl (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign x_o         = bus.X;
    assign busy_o      = bus.busy;
    assign done_o      = bus.done;
    assign pass_o      = bus.pass;
    assign err_count_o = bus.err_count;
    assign fail_map_o  = bus.fail_map;

endmodule

// File: rtl/comb01_bist_ctrl.sv
// BIST controller: steps X through the vector table, checks F.
// clk/rst (sync, active-high); bus: comb01_bist_ctrl_if.slave.
module comb01_bist_ctrl #(
    parameter int N_VEC  = 8,
    parameter int SETTLE = 1
) (
    input logic               clk,
    input logic               rst,
    comb01_bist_ctrl_if.slave bus
);
    import comb01_pkg::*;

    localparam logic [2:0] LAST     = 3'(N_VEC - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] x_q, x_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fmap_q, fmap_d;
    logic       miss;

    assign miss = bus.F != exp_f(tst_vec(idx_q));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        fmap_d   = fmap_q;
        pass_d   = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_APPLY;
                    idx_d    = 3'd0;
                    settle_d = 4'd0;
                    err_d    = 4'd0;
                    fmap_d   = 8'd0;
                    pass_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    settle_d = 4'd0;
                    pass_d   = 1'b0;
                end else if (settle_q == SET_LAST) begin
                    state_d  = ST_SAMPLE;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                // An abort discards this cycle's compare.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (miss) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 4'd1;
                        end
                        fmap_d[idx_q] = 1'b1;
                    end
                    if (idx_q == LAST) begin
                        state_d = ST_DONE;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come out of flops.
    always_comb begin
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        x_d    = busy_d ? tst_vec(idx_d) : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            settle_q <= 4'd0;
            x_q      <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 4'd0;
            fmap_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fmap_q   <= fmap_d;
        end
    end

    assign bus.X         = x_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_map  = fmap_q;

endmodule

// File: tb/tb_comb01_bist_ctrl.sv
// Scoreboard bench for comb01_bist_ctrl.
// Two instances: defaults, and N_VEC=4 / SETTLE=3.
module tb_comb01_bist_ctrl;

    typedef struct {
        int         s;
        logic       p;
        logic [3:0] err;
        logic [7:0] fm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mode = 0;
    int   mode2 = 0;

    exp_t       q1[$];
    exp_t       q2[$];
    logic [2:0] xq1[$];
    logic [2:0] xq2[$];
    exp_t       e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comb01_bist_ctrl_if bus ();
    comb01_bist_ctrl_if bus2 ();

    comb01_bist_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    comb01_bist_ctrl #(.N_VEC(4), .SETTLE(3)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // 0 golden, 1 flip at X=5, 2 stuck-at-0, 3 fully inverted
    function automatic logic model_f(input int m, input logic [2:0] x);
        logic g;
        g = x[0] ^ x[1] ^ x[2];
        case (m)
            1:       return (x == 3'd5) ? ~g : g;
            2:       return 1'b0;
            3:       return ~g;
            default: return g;
        endcase
    endfunction

    always_comb bus.F  = model_f(mode, bus.X);
    always_comb bus2.F = model_f(mode2, bus2.X);

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event with empty scoreboard (cyc %0d)", nm, cyc);
    endfunction

    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            if (xq1.size() == 0) unexpected("busy1");
            else chk("x1", int'(bus.X), int'(xq1.pop_front()));
        end
        if (bus.done === 1'b1) begin
            if (q1.size() == 0) unexpected("done1");
            else begin
                e1 = q1.pop_front();
                chk("latency1", cyc - e1.s + 1, 17);
                chk("pass1", int'(bus.pass), int'(e1.p));
                chk("err1", int'(bus.err_count), int'(e1.err));
                chk("fmap1", int'(bus.fail_map), int'(e1.fm));
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.busy === 1'b1) begin
            if (xq2.size() == 0) unexpected("busy2");
            else chk("x2", int'(bus2.X), int'(xq2.pop_front()));
        end
        if (bus2.done === 1'b1) begin
            if (q2.size() == 0) unexpected("done2");
            else begin
                e2 = q2.pop_front();
                chk("latency2", cyc - e2.s + 1, 17);
                chk("pass2", int'(bus2.pass), int'(e2.p));
                chk("err2", int'(bus2.err_count), int'(e2.err));
                chk("fmap2", int'(bus2.fail_map), int'(e2.fm));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Pulse start on instance 1; nx busy cycles expected.
    task automatic run1(input int nx, input bit fin, input logic p,
                        input logic [3:0] err, input logic [7:0] fm);
        for (int k = 0; k < nx; k++) xq1.push_back(3'(k / 2));
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (fin) q1.push_back('{cyc, p, err, fm});
    endtask

    task automatic run2(input logic p, input logic [3:0] err,
                        input logic [7:0] fm);
        for (int k = 0; k < 16; k++) xq2.push_back(3'(k / 4));
        bus2.start = 1'b1;
        tick(1);
        bus2.start = 1'b0;
        q2.push_back('{cyc, p, err, fm});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_x"}, int'(bus.X), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_pass"}, int'(bus.pass), 0);
        chk({nm, "_err"}, int'(bus.err_count), 0);
        chk({nm, "_fmap"}, int'(bus.fail_map), 0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_zero("reset");
        chk("reset_busy2", int'(bus2.busy), 0);

        // golden run, then a start pulse landing in DONE
        mode = 0;
        run1(16, 1'b1, 1'b1, 4'd0, 8'h00);
        tick(16);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        chk("done_start_ignored", int'(bus.busy), 0);
        chk("pass_held", int'(bus.pass), 1);
        tick(2);

        mode = 1;
        run1(16, 1'b1, 1'b0, 4'd1, 8'h20);
        tick(20);

        mode = 2;
        run1(16, 1'b1, 1'b0, 4'd4, 8'h96);
        tick(20);
        chk("err_held", int'(bus.err_count), 4);

        mode = 3;
        run1(16, 1'b1, 1'b0, 4'd8, 8'hFF);
        tick(20);

        // abort during the SAMPLE of vector 2 (cycle 6)
        mode = 2;
        run1(6, 1'b0, 1'b0, 4'd0, 8'h00);
        tick(5);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_pass", int'(bus.pass), 0);
        chk("abort_err", int'(bus.err_count), 1);
        chk("abort_fmap", int'(bus.fail_map), 8'h02);
        tick(3);

        // start and abort together in IDLE: start wins
        mode = 0;
        bus.abort = 1'b1;
        run1(16, 1'b1, 1'b1, 4'd0, 8'h00);
        tick(20);

        // start held through the run, then reset at cycle 9
        mode = 1;
        for (int k = 0; k < 9; k++) xq1.push_back(3'(k / 2));
        bus.start = 1'b1;
        tick(8);
        chk("held_start_x", int'(bus.X), 3);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk_zero("midrun_rst");
        bus.start = 1'b0;
        rst = 1'b0;
        tick(2);
        chk("post_rst_idle", int'(bus.busy), 0);

        mode2 = 2;
        run2(1'b0, 4'd2, 8'h06);
        tick(20);

        chk("sb1_left", q1.size(), 0);
        chk("x1_left", xq1.size(), 0);
        chk("sb2_left", q2.size(), 0);
        chk("x2_left", xq2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
